// File: rtl/led_schedule_dimmer.sv
`default_nettype none
// ============================================================================
// Module      : led_schedule_dimmer
// Description : Time-of-day LED dimmer. The hour is mapped to a brightness
//               band (night / dawn / day / dusk). Each band has a target
//               level and a channel mask. The output level fades one step
//               per fade tick toward the target. A manual override can
//               replace the schedule. The LED channels are driven by a
//               registered PWM comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module led_schedule_dimmer #(
    parameter int N_LEDS      = 16,
    parameter int PWM_BITS    = 8,
    parameter int FADE_DIV    = 100000,
    parameter int DAY_LEVEL   = 255,
    parameter int TWI_LEVEL   = 128,
    parameter int NIGHT_LEVEL = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [4:0]          i_hours,
    input  logic                i_time_valid,
    input  logic                i_override,
    input  logic [PWM_BITS-1:0] i_override_level,
    output logic [N_LEDS-1:0]   o_leds,
    output logic [PWM_BITS-1:0] o_level,
    output logic                o_fading,
    output logic                o_hour_err
);

    localparam int                C_FD_W      = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [C_FD_W-1:0] C_FD_LAST   = C_FD_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] C_LMAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] C_DAY     = PWM_BITS'(DAY_LEVEL);
    localparam logic [PWM_BITS-1:0] C_TWI     = PWM_BITS'(TWI_LEVEL);
    localparam logic [PWM_BITS-1:0] C_NIGHT   = PWM_BITS'(NIGHT_LEVEL);
    localparam logic [N_LEDS-1:0]   C_MASK_ALL  = {N_LEDS{1'b1}};
    localparam logic [N_LEDS-1:0]   C_MASK_HALF = C_MASK_ALL >> (N_LEDS - N_LEDS / 2);
    localparam logic [N_LEDS-1:0]   C_MASK_QTR  = C_MASK_ALL >> (N_LEDS - N_LEDS / 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PWM_BITS-1:0]   r_sched_target;
    logic [N_LEDS-1:0]     r_sched_mask;
    logic                  r_hour_err;
    logic [PWM_BITS-1:0]   w_band_target;
    logic [N_LEDS-1:0]     w_band_mask;
    logic [PWM_BITS-1:0]   w_target;
    logic [N_LEDS-1:0]     w_mask;
    logic [C_FD_W-1:0]     r_fade_cnt;
    logic                  w_tick;
    logic [PWM_BITS-1:0]   r_level;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [N_LEDS-1:0]     r_leds;

    // Hour-to-band lookup: target level and channel mask for a valid hour.
    always_comb begin
        w_band_target = C_NIGHT;
        w_band_mask   = C_MASK_QTR;
        if (i_hours >= 5'd6 && i_hours <= 5'd7) begin
            w_band_target = C_TWI;
            w_band_mask   = C_MASK_HALF;
        end else if (i_hours >= 5'd8 && i_hours <= 5'd17) begin
            w_band_target = C_DAY;
            w_band_mask   = C_MASK_ALL;
        end else if (i_hours >= 5'd18 && i_hours <= 5'd21) begin
            w_band_target = C_TWI;
            w_band_mask   = C_MASK_HALF;
        end
    end

    // Schedule registers: capture band settings on each valid hour, hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sched_target <= '0;
            r_sched_mask   <= '0;
            r_hour_err     <= 1'b0;
        end else if (i_time_valid) begin
            if (i_hours > 5'd23) begin
                r_sched_target <= '0;
                r_sched_mask   <= '0;
                r_hour_err     <= 1'b1;
            end else begin
                r_sched_target <= w_band_target;
                r_sched_mask   <= w_band_mask;
                r_hour_err     <= 1'b0;
            end
        end
    end

    // Override takes effect immediately; releasing it falls back to the held schedule.
    assign w_target = i_override ? i_override_level : r_sched_target;
    assign w_mask   = i_override ? C_MASK_ALL : r_sched_mask;

    // Fade prescaler: one tick every FADE_DIV cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fade_cnt <= '0;
        end else if (r_fade_cnt == C_FD_LAST) begin
            r_fade_cnt <= '0;
        end else begin
            r_fade_cnt <= r_fade_cnt + 1'b1;
        end
    end

    assign w_tick = (r_fade_cnt == C_FD_LAST);

    // Fade direction state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Direction is re-evaluated every cycle from the current level and target.
    always_comb begin
        w_state_next = S_IDLE;
        if (r_level < w_target) begin
            w_state_next = S_UP;
        end else if (r_level > w_target) begin
            w_state_next = S_DOWN;
        end
    end

    // Level stepping. The live comparison guards against a stale direction
    // for the single cycle after a target change, so the level never overshoots.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= '0;
        end else if (w_tick) begin
            if (r_state == S_UP && r_level < w_target && r_level != C_LMAX) begin
                r_level <= r_level + 1'b1;
            end else if (r_state == S_DOWN && r_level > w_target && r_level != '0) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Free-running PWM period counter, wraps naturally at LMAX.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Registered PWM drive; full brightness is held solidly on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_leds <= '0;
        end else if ((r_level == C_LMAX) || (r_pwm_cnt < r_level)) begin
            r_leds <= w_mask;
        end else begin
            r_leds <= '0;
        end
    end

    assign o_leds     = r_leds;
    assign o_level    = r_level;
    assign o_fading   = (r_state != S_IDLE);
    assign o_hour_err = r_hour_err;

endmodule
`default_nettype wire

// File: tb/tb_led_schedule_dimmer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_schedule_dimmer
// Description : Self-checking bench for led_schedule_dimmer with
//               N_LEDS=8, PWM_BITS=4, FADE_DIV=4, DAY=15, TWI=8, NIGHT=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_schedule_dimmer;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hours;
    logic       time_valid;
    logic       override_en;
    logic [3:0] override_level;
    logic [7:0] leds;
    logic [3:0] level;
    logic       fading;
    logic       hour_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] hour;
        logic [7:0] mask;
        logic [3:0] lvl;
        logic       err;
    } vec_t;

    vec_t vecs [12];

    led_schedule_dimmer #(
        .N_LEDS      (8),
        .PWM_BITS    (4),
        .FADE_DIV    (4),
        .DAY_LEVEL   (15),
        .TWI_LEVEL   (8),
        .NIGHT_LEVEL (2)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_hours          (hours),
        .i_time_valid     (time_valid),
        .i_override       (override_en),
        .i_override_level (override_level),
        .o_leds           (leds),
        .o_level          (level),
        .o_fading         (fading),
        .o_hour_err       (hour_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        time_valid     = 1'b0;
        override_en    = 1'b0;
        override_level = '0;
        hours          = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic apply_hour(input logic [4:0] h);
        hours      = h;
        time_valid = 1'b1;
        step();
        time_valid = 1'b0;
    endtask

    task automatic wait_level(input logic [3:0] lvl, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (level != lvl && cyc < 400);
        check("reach_level", {28'd0, level}, {28'd0, lvl});
    endtask

    task automatic wait_idle(output int cyc, output int maxl);
        cyc  = 0;
        maxl = level;
        step();
        step();
        cyc = 2;
        while (fading && cyc < 400) begin
            step();
            cyc++;
            if (level > maxl) maxl = level;
        end
        check("idle_timeout", {31'd0, fading}, 32'd0);
    endtask

    task automatic measure(input int ch, output logic [7:0] orv, output int cnt);
        orv = '0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            orv = orv | leds;
            if (leds[ch]) cnt++;
        end
    endtask

    initial begin
        int         cyc;
        int         maxl;
        int         cnt;
        logic [7:0] orv;
        logic [7:0] andv;

        vecs[0]  = '{5'd0,  8'h03, 4'd2,  1'b0};
        vecs[1]  = '{5'd5,  8'h03, 4'd2,  1'b0};
        vecs[2]  = '{5'd6,  8'h0F, 4'd8,  1'b0};
        vecs[3]  = '{5'd7,  8'h0F, 4'd8,  1'b0};
        vecs[4]  = '{5'd8,  8'hFF, 4'd15, 1'b0};
        vecs[5]  = '{5'd17, 8'hFF, 4'd15, 1'b0};
        vecs[6]  = '{5'd18, 8'h0F, 4'd8,  1'b0};
        vecs[7]  = '{5'd21, 8'h0F, 4'd8,  1'b0};
        vecs[8]  = '{5'd22, 8'h03, 4'd2,  1'b0};
        vecs[9]  = '{5'd23, 8'h03, 4'd2,  1'b0};
        vecs[10] = '{5'd24, 8'h00, 4'd0,  1'b1};
        vecs[11] = '{5'd31, 8'h00, 4'd0,  1'b1};

        // Reset state
        do_reset();
        check("rst_leds",   {24'd0, leds},     32'd0);
        check("rst_level",  {28'd0, level},    32'd0);
        check("rst_fading", {31'd0, fading},   32'd0);
        check("rst_err",    {31'd0, hour_err}, 32'd0);

        // Day fade-up from 0 to 15, four cycles per step
        apply_hour(5'd12);
        step();
        step();
        check("day_fading", {31'd0, fading}, 32'd1);
        wait_level(4'd15, cyc);
        cyc = cyc + 2;
        check("day_rise_time", {31'd0, (cyc >= 57 && cyc <= 62)}, 32'd1);
        step();
        step();
        andv = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            step();
            andv = andv & leds;
        end
        check("day_leds_const", {24'd0, andv}, 32'h0000_00FF);
        check("day_idle", {31'd0, fading}, 32'd0);

        // Dusk: mask narrows at once, level falls 15 -> 8
        apply_hour(5'd20);
        step();
        check("dusk_mask", {24'd0, leds}, 32'h0000_000F);
        wait_level(4'd8, cyc);
        cyc = cyc + 1;
        check("dusk_fall_time", {31'd0, (cyc >= 25 && cyc <= 30)}, 32'd1);
        wait_idle(cyc, maxl);
        measure(0, orv, cnt);
        check("dusk_duty_ch0", cnt, 32'd8);
        measure(4, orv, cnt);
        check("dusk_duty_ch4", cnt, 32'd0);
        check("dusk_or", {24'd0, orv}, 32'h0000_000F);

        // Reversal: night requested while fading up at level 5
        do_reset();
        apply_hour(5'd12);
        wait_level(4'd5, cyc);
        apply_hour(5'd23);
        wait_idle(cyc, maxl);
        check("rev_max_level", maxl, 32'd5);
        check("rev_level", {28'd0, level}, 32'd2);
        measure(1, orv, cnt);
        check("rev_duty_ch1", cnt, 32'd2);
        check("rev_or", {24'd0, orv}, 32'h0000_0003);

        // Invalid hour then recovery
        apply_hour(5'd25);
        step();
        check("bad_err", {31'd0, hour_err}, 32'd1);
        check("bad_leds", {24'd0, leds}, 32'd0);
        measure(0, orv, cnt);
        check("bad_leds_or", {24'd0, orv}, 32'd0);
        apply_hour(5'd9);
        check("bad_err_clear", {31'd0, hour_err}, 32'd0);

        // Override at day level, then release
        do_reset();
        apply_hour(5'd9);
        wait_idle(cyc, maxl);
        check("ovr_start", {28'd0, level}, 32'd15);
        override_level = 4'd3;
        override_en    = 1'b1;
        wait_idle(cyc, maxl);
        check("ovr_level", {28'd0, level}, 32'd3);
        measure(7, orv, cnt);
        check("ovr_duty_ch7", cnt, 32'd3);
        check("ovr_or", {24'd0, orv}, 32'h0000_00FF);
        override_en = 1'b0;
        wait_idle(cyc, maxl);
        check("ovr_release", {28'd0, level}, 32'd15);

        // Reset beats valid hour and override in the same cycle
        do_reset();
        apply_hour(5'd12);
        wait_level(4'd9, cyc);
        rst            = 1'b1;
        time_valid     = 1'b1;
        hours          = 5'd5;
        override_en    = 1'b1;
        override_level = 4'd7;
        step();
        rst         = 1'b0;
        time_valid  = 1'b0;
        override_en = 1'b0;
        check("rstpri_leds",   {24'd0, leds},     32'd0);
        check("rstpri_level",  {28'd0, level},    32'd0);
        check("rstpri_fading", {31'd0, fading},   32'd0);
        check("rstpri_err",    {31'd0, hour_err}, 32'd0);
        for (int i = 0; i < 8; i++) step();
        check("rstpri_hold_level",  {28'd0, level},  32'd0);
        check("rstpri_hold_fading", {31'd0, fading}, 32'd0);

        // Band table: every band boundary and invalid hours
        for (int v = 0; v < 12; v++) begin
            do_reset();
            apply_hour(vecs[v].hour);
            wait_idle(cyc, maxl);
            check($sformatf("tbl_level_h%0d", vecs[v].hour), {28'd0, level}, {28'd0, vecs[v].lvl});
            check($sformatf("tbl_err_h%0d", vecs[v].hour), {31'd0, hour_err}, {31'd0, vecs[v].err});
            measure(0, orv, cnt);
            check($sformatf("tbl_mask_h%0d", vecs[v].hour), {24'd0, orv}, {24'd0, vecs[v].mask});
            check($sformatf("tbl_duty_h%0d", vecs[v].hour), cnt,
                  (vecs[v].lvl == 4'd15) ? 32'd16 : {28'd0, vecs[v].lvl});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
